dat_mem_arb: RTL and testbench

//  Shares the single-port 256x8 data memory between two masters: m0 = core load/store unit, m1 = DMA/loader.

---
 rtl/dat_mem_pkg.sv | 18 +
 rtl/dat_mem_arb_rr_arb2.sv | 84 ++++++++
 rtl/dat_mem_arb.sv | 115 +++++++++++
 tb/tb_dat_mem_arb.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dat_mem_pkg.sv
// rtl/dat_mem_pkg.sv - shared types and defaults for the data memory arbiter
package dat_mem_pkg;

  localparam int AW_DEF = 8;
  localparam int DW_DEF = 8;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_ARB  = 1'b1
  } arb_state_t;

  typedef enum logic [1:0] {
    G_NONE = 2'd0,
    G_M0   = 2'd1,
    G_M1   = 2'd2
  } gnt_sel_t;

endpackage

// File: rtl/dat_mem_arb_rr_arb2.sv
// rtl/dat_mem_arb_rr_arb2.sv - two-way round-robin grant with bounded burst lock
module rr_arb2
  import dat_mem_pkg::*;
#(
  parameter int MAX_LOCK = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic req0_i,
  input  logic req1_i,
  input  logic lock0_i,
  input  logic lock1_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  localparam logic [3:0] LOCK_LIM = 4'(MAX_LOCK);

  logic       prio_q, prio_d;        // 0 = m0 has priority, 1 = m1
  gnt_sel_t   last_q, last_d;
  logic       lock_q, lock_d;        // lock request of the last granted master
  logic [3:0] lock_cnt_q, lock_cnt_d;
  logic       hold0, hold1;
  gnt_sel_t   sel;

  // Grant selection: a live lock hold overrides the round-robin pointer
  always_comb begin
    hold0 = (last_q == G_M0) && lock_q && req0_i && (lock_cnt_q < LOCK_LIM);
    hold1 = (last_q == G_M1) && lock_q && req1_i && (lock_cnt_q < LOCK_LIM);
    sel   = G_NONE;
    if (en_i && req0_i && req1_i) begin
      if (hold0)       sel = G_M0;
      else if (hold1)  sel = G_M1;
      else             sel = prio_q ? G_M1 : G_M0;
    end else if (en_i && req0_i) begin
      sel = G_M0;
    end else if (en_i && req1_i) begin
      sel = G_M1;
    end
  end

  assign gnt0_o = (sel == G_M0);
  assign gnt1_o = (sel == G_M1);

  // Next-state: hand priority to the other side, count consecutive locked grants
  always_comb begin
    prio_d     = prio_q;
    last_d     = G_NONE;
    lock_d     = 1'b0;
    lock_cnt_d = 4'd0;
    case (sel)
      G_M0: begin
        prio_d     = 1'b1;
        last_d     = G_M0;
        lock_d     = lock0_i;
        lock_cnt_d = hold0 ? (lock_cnt_q + 4'd1) : 4'd1;
      end
      G_M1: begin
        prio_d     = 1'b0;
        last_d     = G_M1;
        lock_d     = lock1_i;
        lock_cnt_d = hold1 ? (lock_cnt_q + 4'd1) : 4'd1;
      end
      default: ;
    endcase
  end

  // Arbitration history registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q     <= 1'b0;
      last_q     <= G_NONE;
      lock_q     <= 1'b0;
      lock_cnt_q <= 4'd0;
    end else begin
      prio_q     <= prio_d;
      last_q     <= last_d;
      lock_q     <= lock_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

endmodule

// File: rtl/dat_mem_arb.sv
// rtl/dat_mem_arb.sv - data memory sharing between core LSU and DMA with zero-fill init
module dat_mem_arb
  import dat_mem_pkg::*;
#(
  parameter int            AW       = AW_DEF,
  parameter int            DW       = DW_DEF,
  parameter int            INIT_EN  = 1,
  parameter logic [DW-1:0] INIT_VAL = '0,
  parameter int            MAX_LOCK = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_wr_en,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dat_in,
  input  logic [DW-1:0] mem_dat_out,
  output logic          init_done
);

  localparam arb_state_t RST_STATE = (INIT_EN != 0) ? ST_INIT : ST_ARB;
  localparam logic       RST_DONE  = (INIT_EN == 0);
  localparam logic [AW-1:0] ONE    = {{(AW-1){1'b0}}, 1'b1};

  arb_state_t    state_q, state_d;
  logic [AW-1:0] init_cnt_q, init_cnt_d;
  logic          init_done_q, init_done_d;
  logic          arb_en;

  // Init sequencer: walk every address once, then open arbitration
  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    if (state_q == ST_INIT) begin
      init_cnt_d = init_cnt_q + ONE;
      if (&init_cnt_q) begin
        state_d     = ST_ARB;
        init_done_d = 1'b1;
      end
    end
  end

  // Sequencer registers; reset always restarts the fill from address 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= RST_DONE;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  assign init_done = init_done_q;
  assign arb_en    = rst_n && (state_q == ST_ARB);

  rr_arb2 #(
    .MAX_LOCK(MAX_LOCK)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (arb_en),
    .req0_i (m0_req),
    .req1_i (m1_req),
    .lock0_i(m0_lock),
    .lock1_i(m1_lock),
    .gnt0_o (m0_gnt),
    .gnt1_o (m1_gnt)
  );

  // Memory port mux; everything is forced low while reset is asserted
  always_comb begin
    mem_wr_en  = 1'b0;
    mem_addr   = '0;
    mem_dat_in = '0;
    if (rst_n) begin
      if (state_q == ST_INIT) begin
        mem_wr_en  = 1'b1;
        mem_addr   = init_cnt_q;
        mem_dat_in = INIT_VAL;
      end else if (m0_gnt) begin
        mem_wr_en  = m0_we;
        mem_addr   = m0_addr;
        mem_dat_in = m0_wdata;
      end else if (m1_gnt) begin
        mem_wr_en  = m1_we;
        mem_addr   = m1_addr;
        mem_dat_in = m1_wdata;
      end
    end
  end

  // Read data is only presented to the master owning a read access this cycle
  always_comb begin
    m0_rdata = (m0_gnt && !m0_we) ? mem_dat_out : '0;
    m1_rdata = (m1_gnt && !m1_we) ? mem_dat_out : '0;
  end

endmodule

// File: tb/tb_dat_mem_arb.sv
// tb/tb_dat_mem_arb.sv - self-checking bench for dat_mem_arb
module tb_dat_mem_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       m0_req, m0_we, m0_lock, m0_gnt;
  logic [7:0] m0_addr, m0_wdata, m0_rdata;
  logic       m1_req, m1_we, m1_lock, m1_gnt;
  logic [7:0] m1_addr, m1_wdata, m1_rdata;
  logic       mem_wr_en, init_done;
  logic [7:0] mem_addr, mem_dat_in, mem_dat_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dat_mem_arb #(
    .AW(8), .DW(8), .INIT_EN(1), .INIT_VAL(8'h00), .MAX_LOCK(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_dat_in(mem_dat_in),
    .mem_dat_out(mem_dat_out), .init_done(init_done)
  );

  // Behavioural 256x8 memory; "junk" preloads non-zero garbage to prove the fill
  logic [7:0] core [256];
  logic       junk = 1'b0;
  always @(posedge clk) begin
    if (junk) begin
      for (int i = 0; i < 256; i++) core[i] <= 8'(i) | 8'h01;
    end else if (mem_wr_en) begin
      core[mem_addr] <= mem_dat_in;
    end
  end
  assign mem_dat_out = core[mem_addr];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: fairness pointer, owner of the previous access, burst length
  int         mp, mlast, mlk, mcnt;
  logic [7:0] rmem [256];

  task automatic model_reset();
    mp = 0; mlast = 0; mlk = 0; mcnt = 0;
    for (int i = 0; i < 256; i++) rmem[i] = 8'h00;
  endtask

  function automatic int predict();
    bit h0, h1;
    h0 = (mlast == 1) && (mlk == 1) && m0_req && (mcnt < 4);
    h1 = (mlast == 2) && (mlk == 1) && m1_req && (mcnt < 4);
    if (m0_req && m1_req) begin
      if (h0) return 1;
      if (h1) return 2;
      return (mp == 0) ? 1 : 2;
    end
    if (m0_req) return 1;
    if (m1_req) return 2;
    return 0;
  endfunction

  task automatic commit(input int sel);
    bit held;
    held = (sel != 0) && (mlast == sel) && (mlk == 1) && (mcnt < 4);
    if (sel == 1) begin
      if (m0_we) rmem[m0_addr] = m0_wdata;
      mlk = int'(m0_lock); mp = 1;
    end else if (sel == 2) begin
      if (m1_we) rmem[m1_addr] = m1_wdata;
      mlk = int'(m1_lock); mp = 0;
    end
    if (sel == 0) begin
      mlast = 0; mcnt = 0; mlk = 0;
    end else begin
      mcnt  = held ? mcnt + 1 : 1;
      mlast = sel;
    end
  endtask

  task automatic check_outputs(input int sel);
    int ewr, ea, ed;
    ewr = (sel == 1) ? int'(m0_we) : (sel == 2) ? int'(m1_we) : 0;
    ea  = (sel == 1) ? int'(m0_addr) : (sel == 2) ? int'(m1_addr) : 0;
    ed  = (sel == 1) ? int'(m0_wdata) : int'(m1_wdata);
    chk("rnd m0_gnt", m0_gnt, sel == 1);
    chk("rnd m1_gnt", m1_gnt, sel == 2);
    chk("rnd m0_rdata", m0_rdata, (sel == 1 && !m0_we) ? int'(rmem[m0_addr]) : 0);
    chk("rnd m1_rdata", m1_rdata, (sel == 2 && !m1_we) ? int'(rmem[m1_addr]) : 0);
    chk("rnd mem_wr_en", mem_wr_en, ewr);
    chk("rnd mem_addr", mem_addr, ea);
    if (ewr != 0) chk("rnd mem_dat_in", mem_dat_in, ed);
  endtask

  // Wait (bounded) for init_done after rst_n rises, then verify the fill
  task automatic run_init(input string tag);
    int lat = 0, gseen = 0, nz = 0;
    for (int k = 1; k <= 300 && lat == 0; k++) begin
      @(posedge clk); #1;
      if ((m0_gnt || m1_gnt) && !init_done) gseen++;
      if (init_done) lat = k;
    end
    chk({tag, " init latency"}, lat, 256);
    chk({tag, " gnt during init"}, gseen, 0);
    for (int i = 0; i < 256; i++) if (core[i] != 8'h00) nz++;
    chk({tag, " nonzero after fill"}, nz, 0);
  endtask

  typedef struct {
    logic r0, w0, l0; logic [7:0] a0, d0;
    logic r1, w1, l1; logic [7:0] a1, d1;
    logic g0, g1; logic [7:0] rd0, rd1;
    logic ce; logic [7:0] ca, cv;
  } vec_t;

  function automatic vec_t mk(logic r0, logic w0, logic l0, logic [7:0] a0, logic [7:0] d0,
                              logic r1, logic w1, logic l1, logic [7:0] a1, logic [7:0] d1,
                              logic g0, logic g1, logic [7:0] rd0, logic [7:0] rd1,
                              logic ce, logic [7:0] ca, logic [7:0] cv);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.l0 = l0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.l1 = l1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.rd0 = rd0; v.rd1 = rd1;
    v.ce = ce; v.ca = ca; v.cv = cv;
    return v;
  endfunction

  task automatic rand_m0();
    m0_req = ($urandom_range(0, 3) != 0); m0_we = 1'($urandom_range(0, 1));
    m0_lock = ($urandom_range(0, 2) == 0); m0_addr = 8'h40 + 8'($urandom_range(0, 7));
    m0_wdata = 8'($urandom);
  endtask

  task automatic rand_m1();
    m1_req = ($urandom_range(0, 3) != 0); m1_we = 1'($urandom_range(0, 1));
    m1_lock = ($urandom_range(0, 2) == 0); m1_addr = 8'h40 + 8'($urandom_range(0, 7));
    m1_wdata = 8'($urandom);
  endtask

  vec_t tbl [15];

  initial begin
    int sel, w0, w1, maxw;
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b0; m0_addr = 8'h00; m0_wdata = 8'h00;
    m1_req = 1'b0; m1_we = 1'b0; m1_lock = 1'b0; m1_addr = 8'h00; m1_wdata = 8'h00;

    // Test 1: reset state, then zero-fill with m0 requesting throughout
    junk = 1'b1;
    repeat (3) @(negedge clk);
    junk = 1'b0;
    @(negedge clk); #1;
    chk("rst m0_gnt", m0_gnt, 0);
    chk("rst mem_wr_en", mem_wr_en, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_init("t1");
    model_reset();

    // Tests 2-5: directed table
    //            r0 w0 l0 a0     d0     r1 w1 l1 a1     d1     g0 g1 rd0    rd1    ce ca     cv
    tbl[0]  = mk(1, 1, 0, 8'h10, 8'hA5, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    tbl[1]  = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 8'h00, 8'hA5, 0, 8'h00, 8'h00);
    tbl[2]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h00, 0, 8'h00, 8'h00);
    tbl[3]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 8'h00, 8'hA5, 0, 8'h00, 8'h00);
    tbl[4]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 1, 0, 8'hA5, 8'h00, 0, 8'h00, 8'h00);
    tbl[5]  = mk(1, 0, 0, 8'h10, 8'h00, 1, 0, 0, 8'h10, 8'h00, 0, 1, 8'h00, 8'hA5, 0, 8'h00, 8'h00);
    tbl[6]  = mk(1, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    for (int i = 7; i <= 10; i++)
      tbl[i] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h00, 0, 1, 8'h00, 8'hA5, 0, 8'h00, 8'h00);
    tbl[11] = mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h10, 8'h00, 1, 0, 8'h00, 8'h00, 0, 8'h00, 8'h00);
    tbl[12] = mk(1, 1, 0, 8'h20, 8'h3C, 1, 1, 0, 8'h20, 8'hC3, 0, 1, 8'h00, 8'h00, 1, 8'h20, 8'hC3);
    tbl[13] = mk(1, 1, 0, 8'h20, 8'h3C, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 8'h20, 8'h3C);
    tbl[14] = mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h20, 8'h00, 0, 1, 8'h00, 8'h3C, 0, 8'h00, 8'h00);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      m0_req = tbl[i].r0; m0_we = tbl[i].w0; m0_lock = tbl[i].l0; m0_addr = tbl[i].a0; m0_wdata = tbl[i].d0;
      m1_req = tbl[i].r1; m1_we = tbl[i].w1; m1_lock = tbl[i].l1; m1_addr = tbl[i].a1; m1_wdata = tbl[i].d1;
      #1;
      sel = predict();
      chk($sformatf("vec%0d m0_gnt", i), m0_gnt, tbl[i].g0);
      chk($sformatf("vec%0d m1_gnt", i), m1_gnt, tbl[i].g1);
      chk($sformatf("vec%0d m0_rdata", i), m0_rdata, tbl[i].rd0);
      chk($sformatf("vec%0d m1_rdata", i), m1_rdata, tbl[i].rd1);
      @(posedge clk);
      commit(sel);
      #1;
      if (tbl[i].ce) chk($sformatf("vec%0d core", i), core[tbl[i].ca], tbl[i].cv);
    end

    // Randomised traffic against the model; requests are held until granted
    @(negedge clk);
    rand_m0(); rand_m1();
    w0 = 0; w1 = 0; maxw = 0;
    for (int c = 0; c < 400; c++) begin
      #1;
      sel = predict();
      check_outputs(sel);
      if (m0_req && !m0_gnt) w0++; else w0 = 0;
      if (m1_req && !m1_gnt) w1++; else w1 = 0;
      if (w0 > maxw) maxw = w0;
      if (w1 > maxw) maxw = w1;
      @(posedge clk);
      commit(sel);
      @(negedge clk);
      if (sel == 1 || !m0_req) rand_m0();
      if (sel == 2 || !m1_req) rand_m1();
    end
    chk("max contention wait", maxw <= 4, 1);

    // Test 6: reset in the middle of an m0 write burst, then again mid-init
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_lock = 1'b1; m0_addr = 8'h05; m0_wdata = 8'hFF;
    #1;
    chk("burst gnt1", m0_gnt, 1);
    @(posedge clk); #1;
    chk("burst core05", core[8'h05], 8'hFF);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 8'h05;
    #1;
    chk("burst gnt2", m0_gnt, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort m0_gnt", m0_gnt, 0);
    chk("abort m1_gnt", m1_gnt, 0);
    chk("abort mem_wr_en", mem_wr_en, 0);
    chk("abort mem_addr", mem_addr, 0);
    chk("abort mem_dat_in", mem_dat_in, 0);
    chk("abort m1_rdata", m1_rdata, 0);
    chk("abort init_done", init_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("mid-init init_done", init_done, 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid-init rst wr_en", mem_wr_en, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_init("t6");
    chk("t6 core05", core[8'h05], 8'h00);

    @(negedge clk);
    m0_req = 1'b0; m1_req = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
